// File: rtl/ttrng_pkg.sv
// Shared types and width helpers for the TTRNG entropy harvester and its FIFO.
package ttrng_pkg;

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } vn_state_e;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of the sample divider counting 0..div-1 (never narrower than 1 bit).
    function automatic int div_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/ttrng_fifo.sv
// First-word-fall-through word FIFO. A push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module ttrng_fifo
    import ttrng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_data_i,
    output logic                      full_o,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          pop_data_o,
    output logic                      empty_o,
    output logic [level_w(DEPTH)-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (level_q == '0);
    assign full_o     = (level_q == FULL_LVL);
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);
    assign level_o    = level_q;
    assign pop_data_o = empty_o ? '0 : mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttrng_harvester.sv
// Entropy harvester: synchronise, XOR-combine, strobe-sample, optional von Neumann
// debias, pack into words and buffer. TTRNG_HEALTH_EN adds the repetition-count test.
module ttrng_harvester
    import ttrng_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int SAMPLE_DIV = 4,
    parameter int RCT_LIMIT  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [N_CH-1:0]           ent_i,
    input  logic [N_CH-1:0]           ch_mask_i,
    input  logic                      debias_i,
    input  logic                      rnd_ready_i,
    output logic [WIDTH-1:0]          rnd_data_o,
    output logic                      rnd_valid_o,
    output logic [level_w(DEPTH)-1:0] fifo_level_o,
    output logic                      overflow_o,
    output logic                      health_fail_o
);
    localparam int DW = div_w(SAMPLE_DIV);
    localparam int CW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    logic [N_CH-1:0]  sync1_q, sync2_q;
    logic [DW-1:0]    div_q, div_d;
    vn_state_e        vn_q, vn_d;
    logic             first_q, first_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic             ovf_q, ovf_d;
    logic             comb, strobe, acc, acc_bit;
    logic [WIDTH-1:0] word;
    logic             word_done, push, block, full, empty, pop;

    assign comb      = ^(sync2_q & ch_mask_i);
    assign strobe    = ena & (div_q == DIV_LAST);
    assign div_d     = (!ena || strobe) ? '0 : div_q + 1'b1;
    assign word      = {sh_q, acc_bit};
    assign word_done = acc & (cnt_q == BIT_LAST);
    assign push      = word_done & ~block;
    assign pop       = rnd_valid_o & rnd_ready_i;
    assign ovf_d     = ovf_q | (push & full & ~pop);

    always_comb begin
        vn_d    = vn_q;
        first_d = first_q;
        acc     = 1'b0;
        acc_bit = comb;
        if (!ena || !debias_i) begin
            vn_d = WAIT_FIRST;
            acc  = strobe & ~debias_i;
        end else if (strobe) begin
            if (vn_q == WAIT_FIRST) begin
                vn_d    = WAIT_SECOND;
                first_d = comb;
            end else begin
                vn_d    = WAIT_FIRST;
                acc     = (comb != first_q);
                acc_bit = first_q;
            end
        end
    end

    // The bit counter wraps on the final bit even when the word is blocked or dropped.
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (!ena) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (acc) begin
            sh_d  = word[WIDTH-2:0];
            cnt_d = (cnt_q == BIT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            div_q   <= '0;
            vn_q    <= WAIT_FIRST;
            first_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= ent_i;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            vn_q    <= vn_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TTRNG_HEALTH_EN
    localparam int RW = $clog2(RCT_LIMIT + 1);
    localparam logic [RW-1:0] RCT_MAX = RW'(RCT_LIMIT);

    logic [RW-1:0] rct_q, rct_d;
    logic          last_q, last_d;
    logic          hf_q, hf_d;

    // A zero count marks "no sample seen yet", so the first strobe always starts a run of 1.
    always_comb begin
        rct_d  = rct_q;
        last_d = last_q;
        hf_d   = hf_q;
        if (!ena) begin
            rct_d = '0;
            hf_d  = 1'b0;
        end else if (strobe) begin
            last_d = comb;
            if (rct_q == '0 || comb != last_q) begin
                rct_d = RW'(1);
            end else if (rct_q != RCT_MAX) begin
                rct_d = rct_q + 1'b1;
            end
            if (rct_d == RCT_MAX) begin
                hf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rct_q  <= '0;
            last_q <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            rct_q  <= rct_d;
            last_q <= last_d;
            hf_q   <= hf_d;
        end
    end

    assign block         = hf_d;
    assign health_fail_o = hf_q;
`else
    logic unused_rct;
    assign unused_rct    = (RCT_LIMIT != 0);
    assign block         = 1'b0;
    assign health_fail_o = 1'b0;
`endif

    ttrng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (word),
        .full_o      (full),
        .pop_i       (pop),
        .pop_data_o  (rnd_data_o),
        .empty_o     (empty),
        .level_o     (fifo_level_o)
    );

    assign rnd_valid_o = ~empty;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ttrng_harvester.sv
// Scoreboard bench for ttrng_harvester: a bit/word-level model queues expected words,
// a monitor pops and compares on every read handshake.
`timescale 1ns/1ps
module tb_ttrng_harvester;
    localparam int N_CH       = 8;
    localparam int WIDTH      = 8;
    localparam int DEPTH      = 4;
    localparam int SAMPLE_DIV = 4;
    localparam int RCT_LIMIT  = 16;
    localparam int LW         = $clog2(DEPTH + 1);
`ifdef TTRNG_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n, ena, debias_i, rnd_ready_i;
    logic [N_CH-1:0]   ent_i, ch_mask_i;
    logic [WIDTH-1:0]  rnd_data_o;
    logic              rnd_valid_o, overflow_o, health_fail_o;
    logic [LW-1:0]     fifo_level_o;

    ttrng_harvester #(
        .N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH),
        .SAMPLE_DIV(SAMPLE_DIV), .RCT_LIMIT(RCT_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ent_i(ent_i), .ch_mask_i(ch_mask_i),
        .debias_i(debias_i), .rnd_ready_i(rnd_ready_i), .rnd_data_o(rnd_data_o),
        .rnd_valid_o(rnd_valid_o), .fifo_level_o(fifo_level_o),
        .overflow_o(overflow_o), .health_fail_o(health_fail_o)
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit               acc_bits[$];
    bit               vn_have, vn_first, m_last, m_hf, m_ovf;
    int               m_run;
    logic [WIDTH-1:0] mon_w;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model of what a harvest session remembers; ena low or reset wipes it.
    function automatic void model_clear();
        acc_bits.delete();
        vn_have = 1'b0;
        m_run   = 0;
        m_hf    = 1'b0;
    endfunction

    // One sample strobe: c is the combined bit, rdy the consumer ready at that edge.
    function automatic void model_step(input bit c, input bit rdy);
        bit               take, b;
        logic [WIDTH-1:0] w;
        take = 1'b0;
        b    = c;
        if (HEALTH) begin
            if (m_run == 0 || c != m_last) m_run = 1;
            else if (m_run < RCT_LIMIT)    m_run++;
            m_last = c;
            if (m_run >= RCT_LIMIT) m_hf = 1'b1;
        end
        if (!debias_i) begin
            take    = 1'b1;
            vn_have = 1'b0;
        end else if (!vn_have) begin
            vn_have  = 1'b1;
            vn_first = c;
        end else begin
            vn_have = 1'b0;
            if (c != vn_first) begin
                take = 1'b1;
                b    = vn_first;
            end
        end
        if (take) begin
            acc_bits.push_back(b);
            if (acc_bits.size() == WIDTH) begin
                w = '0;
                foreach (acc_bits[i]) w = {w[WIDTH-2:0], acc_bits[i]};
                acc_bits.delete();
                if (!m_hf) begin
                    if (exp_q.size() >= DEPTH && !rdy) m_ovf = 1'b1;
                    else exp_q.push_back(w);
                end
            end
        end
    endfunction

    function automatic logic [N_CH-1:0] make_ent(input bit b);
        logic [N_CH-1:0] e;
        bit              done;
        e    = N_CH'($urandom);
        done = 1'b0;
        if ((^(e & ch_mask_i)) != b) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_mask_i[i] && !done) begin
                    e[i] = ~e[i];
                    done = 1'b1;
                end
            end
        end
        return e;
    endfunction

    // Monitor: compare the head on every handshake, and idle data must read zero.
    always @(negedge clk) begin
        if (rnd_valid_o === 1'b1 && rnd_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h, want no word at %0t", rnd_data_o, $time);
            end else begin
                mon_w = exp_q.pop_front();
                chk("pop_data", rnd_data_o, mon_w);
            end
        end else if (rnd_valid_o === 1'b0) begin
            chk("idle_data", rnd_data_o, 0);
        end
    end

    // Called at posedge+1; holds ent for one full sample period so the strobe sees it.
    task automatic sample(input logic [N_CH-1:0] ent, input int rmode);
        bit r;
        ent_i = ent;
        for (int k = 0; k < SAMPLE_DIV; k++) begin
            case (rmode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                3:       r = (k == SAMPLE_DIV - 1);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rnd_ready_i = r;
            if (k == SAMPLE_DIV - 1) model_step(^(ent & ch_mask_i), r);
            @(posedge clk);
            #1;
        end
        rnd_ready_i = 1'b0;
        chk("level", fifo_level_o, exp_q.size());
        chk("valid", rnd_valid_o, exp_q.size() != 0);
        chk("overflow", overflow_o, m_ovf);
        chk("health", health_fail_o, m_hf);
    endtask

    task automatic ena_off();
        ena         = 1'b0;
        rnd_ready_i = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rnd_ready_i = 1'b1;
        for (int k = 0; k < 2 * DEPTH + 2; k++) begin
            if (!rnd_valid_o) break;
            @(posedge clk);
            #1;
        end
        rnd_ready_i = 1'b0;
        chk("drain_level", fifo_level_o, 0);
        chk("drain_scoreboard", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        rnd_ready_i = 1'b0;
        exp_q.delete();
        model_clear();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_level", fifo_level_o, 0);
        chk("rst_valid", rnd_valid_o, 0);
        chk("rst_data", rnd_data_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_health", health_fail_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; ent_i = '0; ch_mask_i = '0;
        debias_i = 1'b0; rnd_ready_i = 1'b0; m_ovf = 1'b0; m_last = 1'b0; vn_first = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", fifo_level_o, 0);
        chk("rst_valid", rnd_valid_o, 0);
        chk("rst_data", rnd_data_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_health", health_fail_o, 0);
        rst_n = 1'b1;

        // Raw constant-one channel 0: one all-ones word
        ch_mask_i = 8'h01;
        ena       = 1'b1;
        repeat (WIDTH) sample(make_ent(1'b1), 0);
        chk("raw_word", rnd_data_o, 8'hFF);
        ena_off();
        drain();

        // Von Neumann pairs (1,0),(1,1),(0,1) accept 1,0
        debias_i = 1'b1;
        ena      = 1'b1;
        repeat (WIDTH / 2) begin
            sample(make_ent(1'b1), 0); sample(make_ent(1'b0), 0);
            sample(make_ent(1'b1), 0); sample(make_ent(1'b1), 0);
            sample(make_ent(1'b0), 0); sample(make_ent(1'b1), 0);
        end
        chk("vn_word", rnd_data_o, 8'hAA);
        repeat (2 * WIDTH) sample(make_ent(1'b1), 0);
        ena_off();
        drain();

        // Overflow: five words with no reader
        debias_i = 1'b0;
        ena      = 1'b1;
        repeat (5 * WIDTH) sample(make_ent(1'b1), 0);
        ena_off();
        chk("overflow_sticky", overflow_o, m_ovf);
        drain();
        do_reset();

        // Full FIFO with a pop in the same cycle as the fifth push
        ena = 1'b1;
        repeat (5 * WIDTH - 1) sample(make_ent(1'b1), 0);
        sample(make_ent(1'b1), 3);
        ena_off();
        drain();

        // Long constant run for the repetition-count test, then a one-cycle ena drop
        ena = 1'b1;
        repeat (RCT_LIMIT + 4) sample(make_ent(1'b0), 0);
        ena_off();
        chk("health_cleared", health_fail_o, 0);
        drain();

        // Reset mid-word with two words stored
        ena = 1'b1;
        repeat (2 * WIDTH + 5) sample(make_ent(1'b1), 0);
        do_reset();
        repeat (WIDTH) sample(make_ent(1'b1), 0);
        ena_off();
        drain();

        // Randomised blocks: mask, mode, entropy and reader all random
        for (int blk = 0; blk < 6; blk++) begin
            ch_mask_i = N_CH'($urandom);
            debias_i  = 1'($urandom_range(0, 1));
            ena       = 1'b1;
            repeat (6 * WIDTH) sample(N_CH'($urandom), 2);
            ena_off();
        end
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
